// File: rtl/led_bar_meter.sv
// LED bar-graph meter: saturates a level to the bar height and slews the displayed bar toward it
// on a periodic tick, with a peak-hold marker and bar/dot display modes.
module led_bar_meter #(
   parameter  int BAR_HEIGHT = 7,
   parameter  int LEVEL_W    = 4,
   parameter  int TICK_MAX   = 166667,
   parameter  int DECAY_DIV  = 2,
   parameter  int PEAK_HOLD  = 30,
   localparam int HW         = $clog2(BAR_HEIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LEVEL_W-1:0]    level,
   input  logic                  mode,
   input  logic                  clear_peak,
   output logic [BAR_HEIGHT-1:0] led,
   output logic [HW-1:0]         height,
   output logic [HW-1:0]         peak
);

   localparam int CW = $clog2(TICK_MAX + 1);
   localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam int PW = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;
   localparam int MW = (LEVEL_W > HW) ? LEVEL_W : HW;

   logic [LEVEL_W-1:0]    level_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [HW-1:0]         height_q, height_d;
   logic [DW-1:0]         decay_q, decay_d;
   logic [HW-1:0]         peak_q, peak_d;
   logic [PW-1:0]         hold_q, hold_d;
   logic [BAR_HEIGHT-1:0] led_q, led_d;

   logic [MW-1:0] level_ext;
   logic [HW-1:0] target;
   logic          tick;

   // Widen both sides before comparing so a narrow level can never wrap against BAR_HEIGHT.
   assign level_ext = MW'(level_q);
   assign target    = (level_ext > MW'(BAR_HEIGHT)) ? HW'(BAR_HEIGHT) : HW'(level_ext);
   assign tick      = (cnt_q == CW'(TICK_MAX)) && (level == level_q);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if ((level != level_q) || (cnt_q == CW'(TICK_MAX))) begin
         cnt_d = '0;
      end
   end

   always_comb begin
      height_d = height_q;
      decay_d  = decay_q;
      if (tick) begin
         if (height_q < target) begin
            height_d = height_q + HW'(1);
            decay_d  = '0;
         end else if (height_q > target) begin
            if (decay_q == DW'(DECAY_DIV - 1)) begin
               height_d = height_q - HW'(1);
               decay_d  = '0;
            end else begin
               decay_d = decay_q + DW'(1);
            end
         end else begin
            decay_d = '0;
         end
      end
   end

   // Peak tracks the next-state height so it never trails the bar by a cycle.
   always_comb begin
      peak_d = peak_q;
      hold_d = hold_q;
      if (clear_peak) begin
         peak_d = height_d;
         hold_d = '0;
      end else if (tick) begin
         if (height_d >= peak_q) begin
            peak_d = height_d;
            hold_d = PW'(PEAK_HOLD);
         end else if (hold_q != '0) begin
            hold_d = hold_q - PW'(1);
         end else begin
            peak_d = peak_q - HW'(1);
         end
      end
   end

   always_comb begin
      led_d = '0;
      for (int k = 1; k <= BAR_HEIGHT; k++) begin
         if (mode ? (height_d == HW'(k)) : (height_d >= HW'(k))) begin
            led_d[BAR_HEIGHT-k] = 1'b1;
         end
         if (peak_d == HW'(k)) begin
            led_d[BAR_HEIGHT-k] = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q  <= '0;
         cnt_q    <= '0;
         height_q <= '0;
         decay_q  <= '0;
         peak_q   <= '0;
         hold_q   <= '0;
         led_q    <= '0;
      end else begin
         level_q  <= level;
         cnt_q    <= cnt_d;
         height_q <= height_d;
         decay_q  <= decay_d;
         peak_q   <= peak_d;
         hold_q   <= hold_d;
         led_q    <= led_d;
      end
   end

   assign led    = led_q;
   assign height = height_q;
   assign peak   = peak_q;

endmodule

// File: tb/tb_led_bar_meter.sv
// Self-checking bench for led_bar_meter: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the meter.
module tb_led_bar_meter;

   localparam int BH = 7;
   localparam int LW = 4;
   localparam int TM = 3;
   localparam int DD = 2;
   localparam int PH = 2;
   localparam int HW = $clog2(BH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [LW-1:0] level = 4'd5;
   logic          mode = 1'b0;
   logic          clear_peak = 1'b0;
   logic [BH-1:0] led;
   logic [HW-1:0] height;
   logic [HW-1:0] peak;

   int checks = 0;
   int failures = 0;

   // Behavioural model state, all plain integers.
   int m_lq = 0, m_cnt = 0, m_h = 0, m_dc = 0, m_pk = 0, m_hold = 0, m_led = 0;

   led_bar_meter #(
      .BAR_HEIGHT(BH),
      .LEVEL_W   (LW),
      .TICK_MAX  (TM),
      .DECAY_DIV (DD),
      .PEAK_HOLD (PH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .level     (level),
      .mode      (mode),
      .clear_peak(clear_peak),
      .led       (led),
      .height    (height),
      .peak      (peak)
   );

   always #5 clk = ~clk;

   function automatic int led_pattern(int h, int p, bit m);
      int r;
      if (m) r = (h > 0) ? (1 << (BH - h)) : 0;
      else   r = ((1 << h) - 1) << (BH - h);
      if (p > 0) r = r | (1 << (BH - p));
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs presented for that edge.
   task automatic model_edge();
      int tgt, nh, ndc, np, nhold;
      bit tk;
      if (rst) begin
         m_lq = 0; m_cnt = 0; m_h = 0; m_dc = 0; m_pk = 0; m_hold = 0; m_led = 0;
      end else begin
         tgt   = (m_lq < BH) ? m_lq : BH;
         tk    = (m_cnt == TM) && (int'(level) == m_lq);
         nh    = m_h;
         ndc   = m_dc;
         np    = m_pk;
         nhold = m_hold;
         if (tk) begin
            if (m_h < tgt) begin
               nh = m_h + 1; ndc = 0;
            end else if (m_h > tgt) begin
               ndc = m_dc + 1;
               if (ndc == DD) begin nh = m_h - 1; ndc = 0; end
            end else begin
               ndc = 0;
            end
         end
         if (clear_peak) begin
            np = nh; nhold = 0;
         end else if (tk) begin
            if (nh >= m_pk) begin np = nh; nhold = PH; end
            else if (m_hold > 0) nhold = m_hold - 1;
            else np = m_pk - 1;
         end
         m_cnt  = ((int'(level) != m_lq) || (m_cnt == TM)) ? 0 : m_cnt + 1;
         m_lq   = int'(level);
         m_h    = nh;
         m_dc   = ndc;
         m_pk   = np;
         m_hold = nhold;
         m_led  = led_pattern(nh, np, mode);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("height", height, m_h);
      check("peak", peak, m_pk);
      check("led", led, m_led);
      check("peak_ge_height", peak >= height, 1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_height(input int h, input int budget);
      int n = 0;
      while (m_h != h && n < budget) begin
         step();
         n++;
      end
      check("wait_height", n < budget, 1);
   endtask

   task automatic run_until_tick_pending(input int budget);
      int n = 0;
      while (m_cnt != TM && n < budget) begin
         step();
         n++;
      end
      check("wait_tick", n < budget, 1);
   endtask

   initial begin
      // Reset and attack
      run(2);
      check("rst_height", height, 0);
      check("rst_peak", peak, 0);
      check("rst_led", led, 0);
      rst = 1'b0;
      step();
      run(3);
      check("attack_pre", height, 0);
      step();
      check("attack_first_h", height, 1);
      check("attack_first_led", led, 7'b1000000);
      run(16);
      check("attack_h5", height, 5);
      check("attack_led5", led, 7'b1111100);
      run(8);
      check("attack_steady", height, 5);

      // Saturation
      level = 4'd15;
      step();
      run(12);
      check("sat_h", height, 7);
      check("sat_peak", peak, 7);
      check("sat_led", led, 7'b1111111);
      run(8);
      check("sat_hold_h", height, 7);
      check("sat_hold_peak", peak, 7);

      // Decay with peak hold
      level = 4'd2;
      step();
      run(60);
      check("decay_h", height, 2);
      check("decay_peak", peak, 2);
      check("decay_led", led, 7'b1100000);

      // Tick restart on every level change
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         level = (i % 2 == 1) ? 4'd4 : 4'd3;
         run(3);
         check("restart_h", height, 0);
      end

      // Dot mode with the peak one segment above the bar
      level = 4'd6;
      run_until_height(6, 60);
      run(8);
      level = 4'd3;
      run_until_height(4, 60);
      check("dot_pre_h", height, 4);
      check("dot_pre_peak", peak, 5);
      mode = 1'b1;
      step();
      check("dot_led", led, 7'b0001100);
      mode = 1'b0;
      step();
      check("bar_led", led, 7'b1111100);

      // clear_peak off a tick, then on a tick that steps the height
      clear_peak = 1'b1;
      step();
      clear_peak = 1'b0;
      check("clr_peak", peak, 4);
      check("clr_led", led, 7'b1111000);
      step();
      run_until_tick_pending(8);
      clear_peak = 1'b1;
      step();
      clear_peak = 1'b0;
      check("clr_tick_h", height, 3);
      check("clr_tick_peak", peak, 3);
      check("clr_tick_led", led, 7'b1110000);

      // Random stimulus against the model
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 11) == 0) level = LW'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         clear_peak = ($urandom_range(0, 29) == 0);
         rst = ($urandom_range(0, 399) == 0);
         step();
      end
      rst = 1'b0;
      clear_peak = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
